// File: rtl/inst_seq_pkg.sv
// Shared definitions for the instruction sequencer: mode codes, FSM state
// encodings and mode normalisation.
package inst_seq_pkg;

    typedef enum logic [1:0] {
        MODE_ONCE = 2'b00,
        MODE_LOOP = 2'b01,
        MODE_STEP = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_ISSUE     = 2'b01,
        ST_GAP       = 2'b10,
        ST_WAIT_STEP = 2'b11
    } state_e;

    // The reserved code behaves exactly like run-once.
    function automatic mode_e norm_mode(input logic [1:0] m);
        if (m == 2'b11) begin
            return MODE_ONCE;
        end
        return mode_e'(m);
    endfunction

endpackage

// File: rtl/seq_prog_ram.sv
// Program store: DEPTH x W words, one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module seq_prog_ram #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/inst_seq.sv
// Instruction sequencer: replays a loaded program as a valid/ready stream in
// run-once, loop or single-step mode, with optional idle gap between words.
//
// state        | meaning
// ST_IDLE      | not running; program may be written or cleared
// ST_ISSUE     | word at ptr presented with inst_vld until accepted
// ST_GAP       | idle spacing after a non-final accept
// ST_WAIT_STEP | single-step mode, waiting for a step pulse
module inst_seq
    import inst_seq_pkg::*;
#(
    parameter int INST_W  = 8,
    parameter int DEPTH   = 16,
    parameter int GAP_CYC = 0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr_en,
    input  logic [INST_W-1:0]          i_wr_data,
    input  logic                       i_clr,
    input  logic [1:0]                 i_mode,
    input  logic                       i_start,
    input  logic                       i_stop,
    input  logic                       i_step,
    output logic [INST_W-1:0]          o_inst_wd,
    output logic                       o_inst_vld,
    input  logic                       i_inst_rdy,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_full,
    output logic                       o_err,
    output logic [$clog2(DEPTH+1)-1:0] o_prog_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int GW = $clog2(GAP_CYC + 2);

    state_e             r_state;
    state_e             w_next;
    mode_e              r_mode;
    logic [AW-1:0]      r_ptr;
    logic [CW-1:0]      r_prog_cnt;
    logic [GW-1:0]      r_gap_cnt;
    logic               r_err;
    logic               r_done;
    logic               r_stop_pend;

    logic               w_idle;
    logic               w_full;
    logic               w_accept;
    logic               w_last;
    logic               w_finish;
    logic               w_start_ok;
    logic               w_we;
    logic               w_err_set;
    logic [INST_W-1:0]  w_rdata;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_full     = (r_prog_cnt == CW'(DEPTH));
    assign w_accept   = (r_state == ST_ISSUE) & i_inst_rdy;
    assign w_last     = (CW'(r_ptr) == (r_prog_cnt - CW'(1)));
    // A stop seen while a word is pending ends the run at that word's accept.
    assign w_finish   = w_accept & ((w_last & (r_mode != MODE_LOOP)) | r_stop_pend | i_stop);
    assign w_start_ok = w_idle & i_start & (r_prog_cnt != '0);
    assign w_we       = w_idle & i_wr_en & ~i_clr & ~w_full;
    assign w_err_set  = (w_idle & i_start & (r_prog_cnt == '0))
                      | (w_idle & i_wr_en & ~i_clr & w_full)
                      | (~w_idle & (i_wr_en | i_clr));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (w_finish) begin
                    w_next = ST_IDLE;
                end else if (w_accept) begin
                    if (GAP_CYC > 0)              w_next = ST_GAP;
                    else if (r_mode == MODE_STEP) w_next = ST_WAIT_STEP;
                    else                          w_next = ST_ISSUE;
                end
            end
            ST_GAP: begin
                if (i_stop) begin
                    w_next = ST_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_next = (r_mode == MODE_STEP) ? ST_WAIT_STEP : ST_ISSUE;
                end
            end
            ST_WAIT_STEP: begin
                if (i_stop)      w_next = ST_IDLE;
                else if (i_step) w_next = ST_ISSUE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_ONCE;
            r_ptr       <= '0;
            r_prog_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_stop_pend <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= ~w_idle & (w_next == ST_IDLE);

            if (w_start_ok) begin
                r_ptr       <= '0;
                r_mode      <= norm_mode(i_mode);
                r_stop_pend <= 1'b0;
            end else begin
                if (w_accept & ~w_finish) begin
                    r_ptr <= w_last ? '0 : r_ptr + AW'(1);
                end
                if ((r_state == ST_ISSUE) & i_stop) begin
                    r_stop_pend <= 1'b1;
                end
            end

            if (w_accept & ~w_finish) begin
                r_gap_cnt <= GW'(GAP_CYC - 1);
            end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GW'(1);
            end

            if (w_idle & i_clr) begin
                r_prog_cnt <= '0;
            end else if (w_we) begin
                r_prog_cnt <= r_prog_cnt + CW'(1);
            end

            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_idle & i_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    seq_prog_ram #(
        .W     (INST_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_prog_cnt[AW-1:0]),
        .i_wdata (i_wr_data),
        .i_raddr (r_ptr),
        .o_rdata (w_rdata)
    );

    assign o_inst_vld = (r_state == ST_ISSUE);
    assign o_inst_wd  = o_inst_vld ? w_rdata : '0;
    assign o_busy     = ~w_idle;
    assign o_done     = r_done;
    assign o_full     = w_full;
    assign o_err      = r_err;
    assign o_prog_cnt = r_prog_cnt;

endmodule

// File: tb/tb_inst_seq.sv
// Bench for inst_seq: two instances (no gap, 2-cycle gap) share stimulus and
// are checked every cycle against a run/queue-level model, plus literal checks.
module tb_inst_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0, clr = 1'b0, start = 1'b0, stop = 1'b0, step = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] wr_data = '0;
    logic [1:0] mode = 2'b00;

    logic [7:0] wd0, wd2;
    logic       vld0, vld2, busy0, busy2, done0, done2, full0, full2, err0, err2;
    logic [4:0] cnt0, cnt2;

    always #5 clk = ~clk;

    inst_seq #(.INST_W(8), .DEPTH(16), .GAP_CYC(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_clr(clr),
        .i_mode(mode), .i_start(start), .i_stop(stop), .i_step(step),
        .o_inst_wd(wd0), .o_inst_vld(vld0), .i_inst_rdy(rdy), .o_busy(busy0),
        .o_done(done0), .o_full(full0), .o_err(err0), .o_prog_cnt(cnt0));

    inst_seq #(.INST_W(8), .DEPTH(16), .GAP_CYC(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data), .i_clr(clr),
        .i_mode(mode), .i_start(start), .i_stop(stop), .i_step(step),
        .o_inst_wd(wd2), .o_inst_vld(vld2), .i_inst_rdy(rdy), .o_busy(busy2),
        .o_done(done2), .o_full(full2), .o_err(err2), .o_prog_cnt(cnt2));

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;

    task automatic chk(input string nm, input int d, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            if (n_fail < 40)
                $display("FAIL %s dut%0d actual=%0h required=%0h t=%0t", nm, d, a, e, $time);
        end
    endtask

    // Model: a run is either presenting word ptr, sitting out gap cycles, or
    // waiting for a step; the program is a plain array with a word count.
    bit         m_act  [2];
    int         m_ptr  [2];
    int         m_mode [2];
    int         m_gapl [2];
    bit         m_ws   [2];
    bit         m_sp   [2];
    bit         m_err  [2];
    bit         m_done [2];
    int         m_cnt  [2];
    logic [7:0] m_mem  [2][16];

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic bit m_vld(input int d);
        return m_act[d] && (m_gapl[d] == 0) && !m_ws[d];
    endfunction

    task automatic model_step(input int d);
        bit was_act;
        int old_cnt;
        was_act   = m_act[d];
        old_cnt   = m_cnt[d];
        m_done[d] = 1'b0;
        if (rst) begin
            m_act[d] = 0; m_ptr[d] = 0; m_gapl[d] = 0; m_ws[d] = 0; m_sp[d] = 0;
            m_err[d] = 0; m_cnt[d] = 0; m_mode[d] = 0;
        end else if (!was_act) begin
            if (clr) begin
                m_cnt[d] = 0; m_err[d] = 0;
            end else if (wr_en) begin
                if (old_cnt == 16) m_err[d] = 1;
                else begin
                    m_mem[d][old_cnt] = wr_data;
                    m_cnt[d] = old_cnt + 1;
                end
            end
            if (start) begin
                if (old_cnt == 0) m_err[d] = 1;
                else begin
                    m_act[d] = 1; m_ptr[d] = 0; m_gapl[d] = 0; m_ws[d] = 0; m_sp[d] = 0;
                    m_mode[d] = (mode == 2'b11) ? 0 : int'(mode);
                end
            end
        end else begin
            if (wr_en || clr) m_err[d] = 1;
            if (m_vld(d)) begin
                if (rdy) begin
                    if (m_sp[d] || stop || (m_ptr[d] == m_cnt[d] - 1 && m_mode[d] != 1)) begin
                        m_act[d] = 0; m_done[d] = 1;
                    end else begin
                        m_ptr[d]  = (m_ptr[d] == m_cnt[d] - 1) ? 0 : m_ptr[d] + 1;
                        m_gapl[d] = gap_of(d);
                        m_ws[d]   = (m_mode[d] == 2);
                    end
                end else if (stop) begin
                    m_sp[d] = 1;
                end
            end else if (m_gapl[d] > 0) begin
                if (stop) begin m_act[d] = 0; m_done[d] = 1; end
                else m_gapl[d] = m_gapl[d] - 1;
            end else begin
                if (stop) begin m_act[d] = 0; m_done[d] = 1; end
                else if (step) m_ws[d] = 0;
            end
        end
    endtask

    int         acc_cyc0[$];
    logic [7:0] acc_wd0[$];
    int         done_cyc0[$];
    int         acc_cyc2[$];

    always @(negedge clk) begin
        logic [7:0] a_wd;
        logic       a_vld, a_busy, a_done, a_full, a_err;
        logic [4:0] a_cnt;
        cyc_n++;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                a_wd = wd0; a_vld = vld0; a_busy = busy0; a_done = done0;
                a_full = full0; a_err = err0; a_cnt = cnt0;
            end else begin
                a_wd = wd2; a_vld = vld2; a_busy = busy2; a_done = done2;
                a_full = full2; a_err = err2; a_cnt = cnt2;
            end
            chk("inst_vld", d, 32'(a_vld), 32'(m_vld(d)));
            if (m_vld(d)) chk("inst_wd", d, 32'(a_wd), 32'(m_mem[d][m_ptr[d]]));
            chk("busy", d, 32'(a_busy), 32'(m_act[d]));
            chk("done", d, 32'(a_done), 32'(m_done[d]));
            chk("full", d, 32'(a_full), 32'(m_cnt[d] == 16));
            chk("err", d, 32'(a_err), 32'(m_err[d]));
            chk("prog_cnt", d, 32'(a_cnt), 32'(m_cnt[d]));
            model_step(d);
        end
        if (vld0 && rdy) begin acc_cyc0.push_back(cyc_n); acc_wd0.push_back(wd0); end
        if (done0) done_cyc0.push_back(cyc_n);
        if (vld2 && rdy) acc_cyc2.push_back(cyc_n);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] w);
        wr_en = 1'b1; wr_data = w;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic clear_logs();
        acc_cyc0.delete(); acc_wd0.delete(); done_cyc0.delete(); acc_cyc2.delete();
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode = m; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Runs until both instances are idle; optionally stalls word 86 for 3 cycles.
    task automatic run_to_idle(input int max, input bit hold86);
        int hold;
        bit ok;
        hold = 0;
        ok = 0;
        for (int i = 0; i < max; i++) begin
            if (!busy0 && !busy2) begin ok = 1; break; end
            if (hold86 && vld0 && wd0 == 8'h86 && hold < 3) begin rdy = 1'b0; hold++; end
            else rdy = 1'b1;
            tick();
        end
        chk("idle_timeout", 0, 32'(ok), 32'd1);
    endtask

    logic [7:0] prog6 [6];
    logic [7:0] w_at_stop;

    initial begin
        prog6[0] = 8'h04; prog6[1] = 8'h00; prog6[2] = 8'h13;
        prog6[3] = 8'h86; prog6[4] = 8'h63; prog6[5] = 8'hC0;
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 0; m_ptr[d] = 0; m_mode[d] = 0; m_gapl[d] = 0; m_ws[d] = 0;
            m_sp[d] = 0; m_err[d] = 0; m_done[d] = 0; m_cnt[d] = 0;
        end

        tick(); tick();
        rst = 1'b0;
        chk("reset_vld", 0, 32'(vld0), 32'd0);
        chk("reset_cnt", 0, 32'(cnt0), 32'd0);

        for (int i = 0; i < 6; i++) write_word(prog6[i]);
        chk("load_cnt", 0, 32'(cnt0), 32'd6);

        // Run-once, rdy always high
        clear_logs();
        rdy = 1'b1;
        pulse_start(2'b00);
        run_to_idle(60, 1'b0);
        tick();
        chk("once_n_acc", 0, 32'(acc_wd0.size()), 32'd6);
        if (acc_wd0.size() == 6 && done_cyc0.size() == 1) begin
            for (int i = 0; i < 6; i++) begin
                chk("once_word", 0, 32'(acc_wd0[i]), 32'(prog6[i]));
                chk("once_b2b", 0, 32'(acc_cyc0[i] - acc_cyc0[0]), 32'(i));
            end
            chk("once_done_lat", 0, 32'(done_cyc0[0] - acc_cyc0[5]), 32'd1);
        end else chk("once_done_n", 0, 32'(done_cyc0.size()), 32'd1);
        chk("gap_n_acc", 2, 32'(acc_cyc2.size()), 32'd6);
        if (acc_cyc2.size() == 6)
            for (int i = 1; i < 6; i++)
                chk("gap_spacing", 2, 32'(acc_cyc2[i] - acc_cyc2[i-1]), 32'd3);

        // Stall on 86
        clear_logs();
        pulse_start(2'b00);
        run_to_idle(60, 1'b1);
        tick();
        chk("stall_n_acc", 0, 32'(acc_wd0.size()), 32'd6);
        if (acc_wd0.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("stall_word", 0, 32'(acc_wd0[i]), 32'(prog6[i]));
            chk("stall_len", 0, 32'(acc_cyc0[3] - acc_cyc0[2]), 32'd4);
        end

        // Loop mode on 04,C0, stop while rdy low
        clr = 1'b1; tick(); clr = 1'b0;
        write_word(8'h04); write_word(8'hC0);
        clear_logs();
        rdy = 1'b1;
        pulse_start(2'b01);
        for (int i = 0; i < 9; i++) tick();
        rdy = 1'b0; stop = 1'b1; w_at_stop = wd0;
        chk("loop_vld_at_stop", 0, 32'(vld0), 32'd1);
        tick();
        stop = 1'b0;
        chk("loop_vld_held", 0, 32'(vld0), 32'd1);
        tick(); tick();
        run_to_idle(40, 1'b0);
        tick();
        chk("loop_n_acc_ge4", 0, 32'(acc_wd0.size() >= 4), 32'd1);
        for (int i = 0; i < acc_wd0.size(); i++)
            chk("loop_word", 0, 32'(acc_wd0[i]), (i % 2 == 0) ? 32'h04 : 32'hC0);
        if (acc_wd0.size() > 0 && done_cyc0.size() == 1) begin
            chk("loop_last_word", 0, 32'(acc_wd0[acc_wd0.size()-1]), 32'(w_at_stop));
            chk("loop_done_lat", 0, 32'(done_cyc0[0] - acc_cyc0[acc_cyc0.size()-1]), 32'd1);
        end else chk("loop_done_n", 0, 32'(done_cyc0.size()), 32'd1);

        // Single-step
        clear_logs();
        rdy = 1'b1;
        pulse_start(2'b10);
        for (int i = 0; i < 6; i++) tick();
        chk("step_n_before", 0, 32'(acc_wd0.size()), 32'd1);
        if (acc_wd0.size() >= 1) chk("step_w0", 0, 32'(acc_wd0[0]), 32'h04);
        chk("step_waiting", 0, 32'(busy0), 32'd1);
        step = 1'b1; tick(); step = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("step_n_after", 0, 32'(acc_wd0.size()), 32'd2);
        if (acc_wd0.size() >= 2) chk("step_w1", 0, 32'(acc_wd0[1]), 32'hC0);
        chk("step_done_n", 0, 32'(done_cyc0.size()), 32'd1);

        // Capacity and error
        clr = 1'b1; tick(); clr = 1'b0;
        for (int i = 0; i < 16; i++) write_word(8'(i * 7 + 1));
        chk("full_at16", 0, 32'(full0), 32'd1);
        chk("cnt_at16", 0, 32'(cnt0), 32'd16);
        chk("err_before17", 0, 32'(err0), 32'd0);
        write_word(8'hEE);
        chk("err_after17", 0, 32'(err0), 32'd1);
        chk("cnt_after17", 0, 32'(cnt0), 32'd16);
        clr = 1'b1; wr_en = 1'b1; wr_data = 8'h55; tick(); clr = 1'b0; wr_en = 1'b0;
        chk("clr_wins_cnt", 0, 32'(cnt0), 32'd0);
        chk("clr_wins_err", 0, 32'(err0), 32'd0);
        pulse_start(2'b00);
        chk("empty_start_err", 0, 32'(err0), 32'd1);
        chk("empty_start_idle", 0, 32'(busy0), 32'd0);

        // Reset mid-run
        write_word(8'h11); write_word(8'h22);
        rdy = 1'b1;
        pulse_start(2'b01);
        tick(); tick();
        chk("midrun_busy", 0, 32'(busy0), 32'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_vld", 0, 32'(vld0), 32'd0);
        chk("rst_done", 0, 32'(done0), 32'd0);
        chk("rst_cnt", 0, 32'(cnt0), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            wr_en = 1'b0; clr = 1'b0; start = 1'b0;
            if (r < 22) begin wr_en = 1'b1; wr_data = 8'($urandom); end
            else if (r < 25) clr = 1'b1;
            else if (r < 38) begin start = 1'b1; mode = 2'($urandom_range(0, 3)); end
            stop = ($urandom_range(0, 99) < 4);
            step = ($urandom_range(0, 99) < 25);
            rdy  = ($urandom_range(0, 99) < 70);
            rst  = ($urandom_range(0, 999) < 5);
            tick();
        end
        wr_en = 1'b0; clr = 1'b0; start = 1'b0; step = 1'b0; rst = 1'b0;
        rdy = 1'b1; stop = 1'b1;
        run_to_idle(40, 1'b0);
        stop = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
